// File: rtl/ultrasonic_presence.sv
// ultrasonic_presence: HC-SR04 presence detector.
// Fires a trigger pulse every PERIOD_CYCLES, measures the echo pulse width and
// turns it into a near/far decision that drives the LCD message controller.
//
// Ports:
//   clk          system clock (50 MHz nominal)
//   reset        synchronous, active-low reset
//   echo         HC-SR04 echo, asynchronous to clk
//   trig         HC-SR04 trigger, high TRIG_CYCLES cycles per period
//   distancia    0 = object near, 1 = nothing near
//   meas_valid   one-cycle pulse when a measurement completes
//   echo_cycles  last echo width in clk cycles (0 on a missing echo)
//   timeout      last measurement timed out; held until the next one
//
// Build option: define ULTRASONIC_FILTER_EN to require FILTER_N consecutive
// disagreeing results before distancia changes. Without it distancia follows
// every measurement directly.
module ultrasonic_presence #(
   parameter int TRIG_CYCLES   = 500,
   parameter int PERIOD_CYCLES = 3000000,
   parameter int ECHO_TIMEOUT  = 1200000,
   parameter int THRESH_CYCLES = 145000,
   parameter int FILTER_N      = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        echo,
   output logic        trig,
   output logic        distancia,
   output logic        meas_valid,
   output logic [21:0] echo_cycles,
   output logic        timeout
);

   localparam logic [21:0] TRIG_L = 22'(TRIG_CYCLES);
   localparam logic [21:0] LAST_L = 22'(PERIOD_CYCLES - 1);
   localparam logic [21:0] TO_L   = 22'(ECHO_TIMEOUT);
   localparam logic [21:0] TO_M1  = 22'(ECHO_TIMEOUT - 1);
   localparam logic [21:0] THR_L  = 22'(THRESH_CYCLES);

   // The whole measurement must fit inside one period, otherwise the fixed
   // trigger cadence would be broken.
   if (TRIG_CYCLES + 2*ECHO_TIMEOUT >= PERIOD_CYCLES)
      $error("ultrasonic_presence: period too short for trigger plus echo window");
   if (FILTER_N < 1)
      $error("ultrasonic_presence: FILTER_N must be at least 1");

   typedef enum logic [1:0] {TRIG, WAIT_RISE, MEASURE, HOLD} state_t;

   state_t      state, state_n;
   logic [21:0] cnt, cnt_n;   // trigger length / rise wait / echo width
   logic [21:0] pcnt;         // position inside the measurement period
   logic        echo_m, echo_s, echo_p;
   logic        rise;
   logic        fin, fin_to, near;
   logic [21:0] fin_cycles;

   // Two-flop synchronizer plus one history flop for rise detection.
   always_ff @(posedge clk) begin
      if (!reset) begin
         echo_m <= 1'b0;
         echo_s <= 1'b0;
         echo_p <= 1'b0;
      end else begin
         echo_m <= echo;
         echo_s <= echo_m;
         echo_p <= echo_s;
      end
   end

   assign rise = echo_s & ~echo_p;

   always_ff @(posedge clk) begin
      if (!reset) state <= TRIG;
      else        state <= state_n;
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      fin        = 1'b0;
      fin_to     = 1'b0;
      fin_cycles = '0;
      case (state)
         TRIG: begin
            if (cnt == TRIG_L) begin
               state_n = WAIT_RISE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 22'd1;
            end
         end
         WAIT_RISE: begin
            // A level already high on entry never produces a rise here.
            if (rise) begin
               state_n = MEASURE;
               cnt_n   = 22'd1;
            end else if (cnt == TO_M1) begin
               fin     = 1'b1;
               fin_to  = 1'b1;
               state_n = HOLD;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 22'd1;
            end
         end
         MEASURE: begin
            if (!echo_s) begin
               fin        = 1'b1;
               fin_cycles = cnt;
               state_n    = HOLD;
               cnt_n      = '0;
            end else if (cnt == TO_M1) begin
               fin        = 1'b1;
               fin_to     = 1'b1;
               fin_cycles = TO_L;
               state_n    = HOLD;
               cnt_n      = '0;
            end else begin
               cnt_n = cnt + 22'd1;
            end
         end
         HOLD: begin
            if (pcnt == LAST_L) begin
               state_n = TRIG;
               cnt_n   = '0;
            end
         end
         default: begin
            state_n = TRIG;
            cnt_n   = '0;
         end
      endcase
   end

   assign near = !fin_to && (fin_cycles < THR_L);

`ifdef ULTRASONIC_FILTER_EN
   localparam int FW = (FILTER_N < 2) ? 1 : $clog2(FILTER_N + 1);
   localparam logic [FW-1:0] FLAST = FW'(FILTER_N - 1);
   logic [FW-1:0] fcnt;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt         <= '0;
         pcnt        <= '0;
         trig        <= 1'b0;
         distancia   <= 1'b1;
         meas_valid  <= 1'b0;
         echo_cycles <= '0;
         timeout     <= 1'b0;
`ifdef ULTRASONIC_FILTER_EN
         fcnt        <= '0;
`endif
      end else begin
         cnt <= cnt_n;
         // Cleared on the edge that enters TRIG, so HOLD's exit compare on
         // PERIOD_CYCLES-1 gives an exact trigger-to-trigger period.
         if (state != TRIG && state_n == TRIG) pcnt <= '0;
         else                                  pcnt <= pcnt + 22'd1;
         // Registered one cycle behind the TRIG counter: after reset or HOLD
         // the pulse starts on the following edge and lasts TRIG_CYCLES.
         trig       <= (state == TRIG) && (cnt != TRIG_L);
         meas_valid <= fin;
         if (fin) begin
            echo_cycles <= fin_cycles;
            timeout     <= fin_to;
`ifdef ULTRASONIC_FILTER_EN
            if (near != distancia) begin
               fcnt <= '0;   // result agrees with the current decision
            end else if (fcnt == FLAST) begin
               fcnt      <= '0;
               distancia <= ~distancia;
            end else begin
               fcnt <= fcnt + 1'b1;
            end
`else
            distancia <= ~near;
`endif
         end
      end
   end

endmodule

// File: tb/tb_ultrasonic_presence.sv
// Bench for ultrasonic_presence with small timing parameters.
// Stimulus: one directed echo pattern per 200-cycle period. The model derives
// expected trigger timing, measurement result and distancia from the period
// schedule and echo widths; a per-cycle compare thread checks the DUT against
// it, and literal expectations pin key points of the sequence.
module tb_ultrasonic_presence;
   localparam int TRIG_C = 5;
   localparam int PER    = 200;
   localparam int ETO    = 60;
   localparam int THR    = 20;
   localparam int FN     = 3;

   logic        clk = 1'b0;
   logic        reset, echo;
   logic        trig, distancia, meas_valid, timeout;
   logic [21:0] echo_cycles;

   ultrasonic_presence #(
      .TRIG_CYCLES(TRIG_C), .PERIOD_CYCLES(PER), .ECHO_TIMEOUT(ETO),
      .THRESH_CYCLES(THR), .FILTER_N(FN)
   ) dut (
      .clk(clk), .reset(reset), .echo(echo), .trig(trig),
      .distancia(distancia), .meas_valid(meas_valid),
      .echo_cycles(echo_cycles), .timeout(timeout)
   );

   always #5 clk = ~clk;

   // Edges seen with reset released; 0 while in reset.
   int cyc = 0;
   always @(posedge clk) begin
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   int checks, fails;
   bit started, abort;
   int exp_ec, held_ec;
   bit exp_to, held_to, mdist;
   int mfc, mv_cnt, s;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d (cyc=%0d)", nm, act, req, cyc);
      end
   endtask

   // Decision rule applied to one finished measurement.
   task automatic model_update();
      bit far;
      far = exp_to || (exp_ec >= THR);
`ifdef ULTRASONIC_FILTER_EN
      if (far == mdist) mfc = 0;
      else begin
         mfc++;
         if (mfc == FN) begin
            mdist = ~mdist;
            mfc   = 0;
         end
      end
`else
      mdist = far;
`endif
   endtask

   task automatic cmp_cycle();
      if (cyc == 0) begin
         mdist = 1'b1; mfc = 0; held_ec = 0; held_to = 1'b0; mv_cnt = 0;
         chk("mv_in_reset", meas_valid, 0);
      end
      chk("trig", trig, (cyc == 0) ? 0 : (((cyc - 1) % PER) < TRIG_C));
      if (cyc > 1 && ((cyc - 1) % PER) == 0) begin
         chk("mv_per_period", mv_cnt, 1);
         mv_cnt = 0;
      end
      if (abort) chk("mv_aborted", meas_valid, 0);
      if (meas_valid === 1'b1 && !abort) begin
         mv_cnt++;
         held_ec = exp_ec;
         held_to = exp_to;
         model_update();
      end
      chk("echo_cycles", echo_cycles, held_ec);
      chk("timeout", timeout, held_to);
      chk("distancia", distancia, mdist);
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Echo raised after edge s+off for w edges; w==0 means no echo.
   task automatic run_period(input int off, input int w);
      abort = 1'b0;
      if (w == 0 || off < 6) begin
         // missing echo, or echo already high before the rise window (and
         // falling inside it): no qualifying rise
         exp_ec = 0; exp_to = 1'b1;
      end else if (w >= ETO) begin
         exp_ec = ETO; exp_to = 1'b1;
      end else begin
         exp_ec = w; exp_to = 1'b0;
      end
      if (w > 0) begin
         wait_cyc(s + off);
         echo = 1'b1;
         wait_cyc(s + off + w);
         echo = 1'b0;
      end
      s += PER;
      wait_cyc(s);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; fails = 0; started = 0; abort = 0;
      mdist = 1'b1; mfc = 0; held_ec = 0; held_to = 0; mv_cnt = 0;
      exp_ec = 0; exp_to = 0; s = 1;
      reset = 1'b0; echo = 1'b0;
      fork
         forever begin
            @(negedge clk);
            if (started) cmp_cycle();
         end
      join_none
      repeat (3) @(posedge clk);
      #1;
      chk("rst_trig", trig, 0);
      chk("rst_distancia", distancia, 1);
      chk("rst_meas_valid", meas_valid, 0);
      chk("rst_echo_cycles", echo_cycles, 0);
      chk("rst_timeout", timeout, 0);
      started = 1'b1;
      reset   = 1'b1;

      // no echo: timeout results, distancia stays far
      run_period(0, 0);
      chk("lit_noecho_ec", echo_cycles, 0);
      chk("lit_noecho_to", timeout, 1);
      chk("lit_noecho_dist", distancia, 1);
      run_period(0, 0);
      // three near results
      run_period(15, 10);
      chk("lit_w10_ec", echo_cycles, 10);
      chk("lit_w10_to", timeout, 0);
`ifdef ULTRASONIC_FILTER_EN
      chk("lit_w10_dist_first", distancia, 1);
`else
      chk("lit_w10_dist_first", distancia, 0);
`endif
      run_period(15, 10);
      run_period(15, 10);
      chk("lit_w10_dist_third", distancia, 0);
      chk("lit_model_dist_third", mdist, 0);
      // threshold edge: 19 near, 20 far
      run_period(15, 19);
      chk("lit_w19_ec", echo_cycles, 19);
      chk("lit_w19_dist", distancia, 0);
      run_period(15, 20);
      chk("lit_w20_ec", echo_cycles, 20);
      chk("lit_w20_to", timeout, 0);
`ifdef ULTRASONIC_FILTER_EN
      chk("lit_w20_dist", distancia, 0);
`else
      chk("lit_w20_dist", distancia, 1);
`endif
      // near to clear the filter, then far,far,near,far,far,far
      run_period(15, 10);
      run_period(15, 30);
      run_period(15, 100);
      chk("lit_w100_ec", echo_cycles, 60);
      chk("lit_w100_to", timeout, 1);
      run_period(15, 10);
      run_period(15, 20);
      run_period(15, 0);
`ifdef ULTRASONIC_FILTER_EN
      chk("lit_pattern5_dist", distancia, 0);
`else
      chk("lit_pattern5_dist", distancia, 1);
`endif
      run_period(15, 30);
      chk("lit_pattern6_dist", distancia, 1);
      chk("lit_model_pattern6", mdist, 1);
      // echo already high while the trigger is active
      run_period(1, 30);
      chk("lit_prehigh_ec", echo_cycles, 0);
      chk("lit_prehigh_to", timeout, 1);

      // reset in the middle of an echo measurement
      abort = 1'b1;
      wait_cyc(s + 15);
      echo = 1'b1;
      wait_cyc(s + 20);
      reset = 1'b0;
      @(posedge clk);
      #1;
      echo = 1'b0;
      chk("midrst_trig", trig, 0);
      chk("midrst_mv", meas_valid, 0);
      chk("midrst_dist", distancia, 1);
      chk("midrst_ec", echo_cycles, 0);
      chk("midrst_to", timeout, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      s = 1;
      @(posedge clk);
      #1;
      chk("post_rst_trig_rise", trig, 1);
      run_period(15, 10);
      chk("lit_post_rst_ec", echo_cycles, 10);
`ifdef ULTRASONIC_FILTER_EN
      chk("lit_post_rst_dist", distancia, 1);
`else
      chk("lit_post_rst_dist", distancia, 0);
`endif
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
